// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_unit
// Description : Control side of the EX-stage operand forwarding network.
//               Tracks destination-register tags for the EX, MEM and WB
//               slots, produces the fa/fb forwarding selects, detects
//               load-use hazards (one-cycle stall plus bubble), honours the
//               EX-stage branch flush and counts stall cycles.
// Ports       : clk, rst_n          - clock, async active-low reset
//               id_*                 - decoded fields of the instruction in ID
//               flush                - taken branch in EX, kill IF/ID
//               fa, fb               - EX operand selects (10 EX/MEM,
//                                      01 MEM/WB, 00 register file)
//               stall                - hold PC and IF/ID, bubble into EX
//               stall_cnt            - saturating stall-cycle counter
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic [1:0]        fa,
  output logic [1:0]        fb,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  // EX slot: full operand information for the instruction being executed.
  logic              r_ex_v;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_rw;
  logic              r_ex_mr;
  logic [REG_AW-1:0] r_ex_rs1;
  logic [REG_AW-1:0] r_ex_rs2;
  logic              r_ex_u1;
  logic              r_ex_u2;

  // MEM and WB slots only need producer information. The load flag is not
  // carried past EX: the load-use stall already guarantees a load in MEM is
  // never a forwarding source, so nothing downstream consumes it.
  logic              r_mem_v;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_mem_rw;
  logic              r_wb_v;
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_rw;

  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_mem_prod;
  logic              w_wb_prod;
  logic              w_ex_load_prod;
  logic              w_stall;
  logic              w_ex_take;

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A write to r0 is architecturally discarded, so it never produces data.
  assign w_mem_prod     = r_mem_v && r_mem_rw && (r_mem_rd != '0);
  assign w_wb_prod      = r_wb_v  && r_wb_rw  && (r_wb_rd  != '0);
  assign w_ex_load_prod = r_ex_v  && r_ex_mr  && (r_ex_rd  != '0);

  // Forwarding selects depend on flops only. MEM is checked first so the
  // youngest in-flight write wins when both slots target the same register.
  always_comb begin
    fa = 2'b00;
    if (r_ex_u1 && w_mem_prod && (r_mem_rd == r_ex_rs1)) begin
      fa = 2'b10;
    end else if (r_ex_u1 && w_wb_prod && (r_wb_rd == r_ex_rs1)) begin
      fa = 2'b01;
    end
  end

  always_comb begin
    fb = 2'b00;
    if (r_ex_u2 && w_mem_prod && (r_mem_rd == r_ex_rs2)) begin
      fb = 2'b10;
    end else if (r_ex_u2 && w_wb_prod && (r_wb_rd == r_ex_rs2)) begin
      fb = 2'b01;
    end
  end

  // Flush wins over stall: the consumer in ID is being killed anyway.
  assign w_stall = id_valid && !flush && w_ex_load_prod &&
                   ((id_use_rs1 && (id_rs1 == r_ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == r_ex_rd)));

  assign w_ex_take = id_valid && !flush && !w_stall;

  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_v      <= 1'b0;
      r_ex_rd     <= '0;
      r_ex_rw     <= 1'b0;
      r_ex_mr     <= 1'b0;
      r_ex_rs1    <= '0;
      r_ex_rs2    <= '0;
      r_ex_u1     <= 1'b0;
      r_ex_u2     <= 1'b0;
      r_mem_v     <= 1'b0;
      r_mem_rd    <= '0;
      r_mem_rw    <= 1'b0;
      r_wb_v      <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_rw     <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_wb_v   <= r_mem_v;
      r_wb_rd  <= r_mem_rd;
      r_wb_rw  <= r_mem_rw;
      r_mem_v  <= r_ex_v;
      r_mem_rd <= r_ex_rd;
      r_mem_rw <= r_ex_rw;

      // A bubble clears every field, including the use bits, so a dead EX
      // slot can never raise a forwarding select.
      if (w_ex_take) begin
        r_ex_v   <= 1'b1;
        r_ex_rd  <= id_rd;
        r_ex_rw  <= id_regwrite;
        r_ex_mr  <= id_memread;
        r_ex_rs1 <= id_rs1;
        r_ex_rs2 <= id_rs2;
        r_ex_u1  <= id_use_rs1;
        r_ex_u2  <= id_use_rs2;
      end else begin
        r_ex_v   <= 1'b0;
        r_ex_rd  <= '0;
        r_ex_rw  <= 1'b0;
        r_ex_mr  <= 1'b0;
        r_ex_rs1 <= '0;
        r_ex_rs2 <= '0;
        r_ex_u1  <= 1'b0;
        r_ex_u2  <= 1'b0;
      end

      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_hazard_unit
// Description : Directed self-checking bench for fwd_hazard_unit. Expected
//               selects, stall and counter values are queued when each
//               instruction is driven into ID and compared on the following
//               falling edge.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

  localparam int REG_AW = 3;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_regwrite;
  logic              id_memread;
  logic              flush;
  logic [1:0]        fa;
  logic [1:0]        fb;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;

  fwd_hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rd      (id_rd),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_regwrite(id_regwrite),
    .id_memread (id_memread),
    .flush      (flush),
    .fa         (fa),
    .fb         (fb),
    .stall      (stall),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              u1;
    logic              u2;
    logic              rw;
    logic              mr;
  } instr_t;

  typedef struct packed {
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             st;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             q[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  logic [CNT_W-1:0] e_cnt   = '0;

  function automatic instr_t alu(input int rd, input int rs1, input int rs2);
    instr_t i;
    i = '{v:1'b1, rs1:REG_AW'(rs1), rs2:REG_AW'(rs2), rd:REG_AW'(rd),
          u1:1'b1, u2:1'b1, rw:1'b1, mr:1'b0};
    return i;
  endfunction

  function automatic instr_t ld(input int rd, input int rs1);
    instr_t i;
    i = '{v:1'b1, rs1:REG_AW'(rs1), rs2:'0, rd:REG_AW'(rd),
          u1:1'b1, u2:1'b0, rw:1'b1, mr:1'b1};
    return i;
  endfunction

  function automatic instr_t nop();
    instr_t i;
    i = '0;
    return i;
  endfunction

  task automatic drive(input instr_t in, input logic fl);
    id_valid    = in.v;
    id_rs1      = in.rs1;
    id_rs2      = in.rs2;
    id_rd       = in.rd;
    id_use_rs1  = in.u1;
    id_use_rs2  = in.u2;
    id_regwrite = in.rw;
    id_memread  = in.mr;
    flush       = fl;
  endtask

  task automatic push(input logic [1:0] efa, input logic [1:0] efb, input logic est);
    exp_t e;
    e.fa  = efa;
    e.fb  = efb;
    e.st  = est;
    e.cnt = e_cnt;
    q.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    n_tests++;
    assert (q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s scoreboard: observed empty queue, expected an entry", tag);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      n_tests++;
      assert (fa === e.fa) else begin
        n_fail++;
        $error("FAIL %s fa: observed %b expected %b", tag, fa, e.fa);
      end
      n_tests++;
      assert (fb === e.fb) else begin
        n_fail++;
        $error("FAIL %s fb: observed %b expected %b", tag, fb, e.fb);
      end
      n_tests++;
      assert (stall === e.st) else begin
        n_fail++;
        $error("FAIL %s stall: observed %b expected %b", tag, stall, e.st);
      end
      n_tests++;
      assert (stall_cnt === e.cnt) else begin
        n_fail++;
        $error("FAIL %s stall_cnt: observed %0d expected %0d", tag, stall_cnt, e.cnt);
      end
    end
  endtask

  // One ID cycle: drive just after the rising edge, compare on the falling
  // edge, then advance to the next rising edge.
  task automatic step(input instr_t in, input logic fl, input logic [1:0] efa,
                      input logic [1:0] efb, input logic est, input string tag);
    drive(in, fl);
    push(efa, efb, est);
    @(negedge clk);
    check(tag);
    if (est && (e_cnt != {CNT_W{1'b1}})) e_cnt = e_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) step(nop(), 1'b0, 2'b00, 2'b00, 1'b0, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    drive(nop(), 1'b0);
    #1 rst_n = 1'b0;
    #1;
    push(2'b00, 2'b00, 1'b0);
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2, "idle");

    // Back-to-back ALU: SUB r2,r1,r3 after ADD r1
    step(alu(1, 2, 3), 1'b0, 2'b00, 2'b00, 1'b0, "b2b_add");
    step(alu(2, 1, 3), 1'b0, 2'b00, 2'b00, 1'b0, "b2b_sub_id");
    step(nop(),        1'b0, 2'b10, 2'b00, 1'b0, "b2b_sub_ex");
    idle(2, "b2b_drain");

    // Distance 2: ADD r4, NOP, AND r5,r0,r4
    step(alu(4, 1, 2), 1'b0, 2'b00, 2'b00, 1'b0, "d2_add");
    step(nop(),        1'b0, 2'b00, 2'b00, 1'b0, "d2_nop");
    step(alu(5, 0, 4), 1'b0, 2'b00, 2'b00, 1'b0, "d2_and_id");
    step(nop(),        1'b0, 2'b00, 2'b01, 1'b0, "d2_and_ex");
    idle(2, "d2_drain");

    // Priority: ADD r4, ADD r4, OR r6,r4,r4
    step(alu(4, 1, 2), 1'b0, 2'b00, 2'b00, 1'b0, "pri_add1");
    step(alu(4, 1, 2), 1'b0, 2'b00, 2'b00, 1'b0, "pri_add2");
    step(alu(6, 4, 4), 1'b0, 2'b00, 2'b00, 1'b0, "pri_or_id");
    step(nop(),        1'b0, 2'b10, 2'b10, 1'b0, "pri_or_ex");
    idle(2, "pri_drain");

    // Load-use: LW r2 then ADD r3,r2,r1; ID held for one stalled cycle
    step(ld(2, 1),     1'b0, 2'b00, 2'b00, 1'b0, "lu_lw");
    step(alu(3, 2, 1), 1'b0, 2'b00, 2'b00, 1'b1, "lu_stall");
    step(alu(3, 2, 1), 1'b0, 2'b00, 2'b00, 1'b0, "lu_release");
    step(nop(),        1'b0, 2'b01, 2'b00, 1'b0, "lu_fwd");
    idle(2, "lu_drain");

    // Flush beats stall; EX receives a bubble so the refetched ADD is clean
    step(ld(2, 1),     1'b0, 2'b00, 2'b00, 1'b0, "fl_lw");
    step(alu(3, 2, 2), 1'b1, 2'b00, 2'b00, 1'b0, "fl_flush");
    step(alu(3, 2, 2), 1'b0, 2'b00, 2'b00, 1'b0, "fl_ex_bubble");
    step(nop(),        1'b0, 2'b01, 2'b01, 1'b0, "fl_fwd");
    idle(2, "fl_drain");

    // r0: writes to r0 never forward, a load to r0 never stalls
    step(alu(0, 1, 2), 1'b0, 2'b00, 2'b00, 1'b0, "r0_add");
    step(alu(7, 0, 0), 1'b0, 2'b00, 2'b00, 1'b0, "r0_sub_id");
    step(ld(0, 1),     1'b0, 2'b00, 2'b00, 1'b0, "r0_sub_ex");
    step(alu(3, 0, 0), 1'b0, 2'b00, 2'b00, 1'b0, "r0_ld_nostall");
    step(nop(),        1'b0, 2'b00, 2'b00, 1'b0, "r0_use_ex");
    idle(2, "r0_drain");

    // Reset dropped mid-stall, with fa also non-zero at that moment
    step(alu(1, 5, 6), 1'b0, 2'b00, 2'b00, 1'b0, "rm_add");
    step(ld(2, 1),     1'b0, 2'b00, 2'b00, 1'b0, "rm_lw");
    drive(alu(3, 2, 1), 1'b0);
    push(2'b10, 2'b00, 1'b1);
    @(negedge clk);
    check("rm_stall");
    #1 rst_n = 1'b0;
    e_cnt = '0;
    #1;
    push(2'b00, 2'b00, 1'b0);
    check("rm_async");
    @(posedge clk);
    #1;
    drive(nop(), 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(1, "rm_after");

    // Saturation: 20 load-use pairs into a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      step(ld(2, 1),     1'b0, (i == 0) ? 2'b00 : 2'b01, 2'b00, 1'b0, "sat_lw");
      step(alu(3, 2, 1), 1'b0, 2'b00, 2'b00, 1'b1, "sat_stall");
      step(alu(3, 2, 1), 1'b0, 2'b00, 2'b00, 1'b0, "sat_hold");
    end
    step(nop(), 1'b0, 2'b01, 2'b00, 1'b0, "sat_last_fwd");
    n_tests++;
    assert (stall_cnt === 4'd15) else begin
      n_fail++;
      $error("FAIL sat_value: observed %0d expected 15", stall_cnt);
    end
    idle(2, "sat_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
